// File: rtl/ppe_stream_engine.sv
// Partial-sum processing element: holds a signed weight row and a spike row, then
// streams one partial sum per output column round-robin to SPEs and requests the next row.
module ppe_stream_engine #(
    parameter int FILTER_SIZE  = 5,
    parameter int IFMAP_SIZE   = 25,
    parameter int WEIGHT_WIDTH = 8,
    parameter int SUM_WIDTH    = 14,
    parameter int NUM_SPE      = 5,
    parameter int ROWS_PER_TS  = 5,
    parameter int PE_ID        = 0,
    parameter int IMEM_ID      = 11
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_opcode,
    input  logic [24:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  out_dest,
    output logic [3:0]  out_opcode,
    output logic [24:0] out_data,
    output logic        weights_loaded,
    output logic        busy,
    output logic [2:0]  row_cnt,
    output logic        err
);
    localparam int OUTPUT_DIM = IFMAP_SIZE - FILTER_SIZE + 1;
    localparam int IDX_W      = $clog2(IFMAP_SIZE);
    localparam int TAP_W      = $clog2(FILTER_SIZE);
    localparam int WPTR_W     = $clog2(FILTER_SIZE + 1);
    localparam int K          = 25 / WEIGHT_WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_SEND, S_REQ} state_t;

    state_t                         state_q, state_d;
    logic                           in_ready_q, in_ready_d;
    logic                           out_valid_q, out_valid_d;
    logic [3:0]                     out_dest_q, out_dest_d;
    logic [3:0]                     out_opcode_q, out_opcode_d;
    logic [24:0]                    out_data_q, out_data_d;
    logic [WPTR_W-1:0]              wptr_q, wptr_d;
    logic [2:0]                     row_cnt_q, row_cnt_d;
    logic [3:0]                     dest_pe_q, dest_pe_d;
    logic                           err_q, err_d;
    logic [IDX_W-1:0]               col_q, col_d;
    logic [TAP_W-1:0]               tap_q, tap_d;
    logic signed [SUM_WIDTH-1:0]    acc_q, acc_d;
    logic [IFMAP_SIZE-1:0]          spike_q, spike_d;
    logic signed [WEIGHT_WIDTH-1:0] weight_q [FILTER_SIZE];
    logic signed [WEIGHT_WIDTH-1:0] weight_d [FILTER_SIZE];

    function automatic logic signed [SUM_WIDTH-1:0] ext_w(input logic signed [WEIGHT_WIDTH-1:0] w);
        return {{(SUM_WIDTH-WEIGHT_WIDTH){w[WEIGHT_WIDTH-1]}}, w};
    endfunction

    function automatic logic [24:0] ext_out(input logic signed [SUM_WIDTH-1:0] a);
        return {{(25-SUM_WIDTH){a[SUM_WIDTH-1]}}, a};
    endfunction

    logic                        accept, out_hs, loaded, last_tap, last_col, row_more, in_ok;
    logic [2:0]                  row_next;
    logic [WPTR_W-1:0]           wbase;
    logic [IDX_W-1:0]            sidx;
    logic signed [SUM_WIDTH-1:0] term, acc_sum;

    assign accept   = in_valid & in_ready_q;
    assign out_hs   = out_valid_q & out_ready;
    assign loaded   = (wptr_q == WPTR_W'(FILTER_SIZE));
    assign last_tap = (tap_q == TAP_W'(FILTER_SIZE - 1));
    assign last_col = (col_q == IDX_W'(OUTPUT_DIM - 1));
    assign row_next = row_cnt_q + 3'd1;
    assign row_more = (int'(row_next) < ROWS_PER_TS);
    assign in_ok    = loaded && (int'(row_cnt_q) != ROWS_PER_TS);
    // A weight packet on a full row starts a fresh load from tap 0.
    assign wbase    = loaded ? '0 : wptr_q;
    assign sidx     = col_q + IDX_W'(tap_q);
    assign term     = spike_q[sidx] ? ext_w(weight_q[tap_q]) : '0;
    assign acc_sum  = acc_q + term;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept && in_opcode == 4'd1 && in_ok) state_d = S_MAC;
            S_MAC:  if (last_tap) state_d = S_SEND;
            S_SEND: if (out_hs) state_d = last_col ? (row_more ? S_REQ : S_IDLE) : S_MAC;
            S_REQ:  if (out_hs) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready_d   = (state_d == S_IDLE);
        out_valid_d  = out_valid_q;
        out_dest_d   = out_dest_q;
        out_opcode_d = out_opcode_q;
        out_data_d   = out_data_q;
        wptr_d       = wptr_q;
        row_cnt_d    = row_cnt_q;
        dest_pe_d    = dest_pe_q;
        err_d        = 1'b0;
        col_d        = col_q;
        tap_d        = tap_q;
        acc_d        = acc_q;
        spike_d      = spike_q;
        weight_d     = weight_q;
        case (state_q)
            S_IDLE: if (accept) begin
                case (in_opcode)
                    4'd0: begin
                        for (int j = 0; j < FILTER_SIZE; j++)
                            for (int k = 0; k < K; k++)
                                if (int'(wbase) + k == j)
                                    weight_d[j] = in_data[(k+1)*WEIGHT_WIDTH-1 -: WEIGHT_WIDTH];
                        wptr_d = (int'(wbase) + K >= FILTER_SIZE) ? WPTR_W'(FILTER_SIZE)
                                                                   : wbase + WPTR_W'(K);
                    end
                    4'd1: begin
                        if (in_ok) begin
                            spike_d = in_data[IFMAP_SIZE-1:0];
                            col_d   = '0;
                            tap_d   = '0;
                            acc_d   = '0;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                    4'd15: begin
                        row_cnt_d = '0;
                        dest_pe_d = '0;
                    end
                    default: err_d = 1'b1;
                endcase
            end
            S_MAC: begin
                acc_d = acc_sum;
                tap_d = tap_q + TAP_W'(1);
                if (last_tap) begin
                    out_valid_d  = 1'b1;
                    out_dest_d   = dest_pe_q;
                    out_opcode_d = 4'd0;
                    out_data_d   = ext_out(acc_sum);
                end
            end
            S_SEND: if (out_hs) begin
                dest_pe_d    = (dest_pe_q == 4'(NUM_SPE - 1)) ? 4'd0 : dest_pe_q + 4'd1;
                col_d        = col_q + IDX_W'(1);
                out_valid_d  = 1'b0;
                out_dest_d   = '0;
                out_opcode_d = '0;
                out_data_d   = '0;
                tap_d        = '0;
                acc_d        = '0;
                if (last_col) begin
                    row_cnt_d = row_next;
                    // The IMEM request is presented straight after the last sum.
                    if (row_more) begin
                        out_valid_d  = 1'b1;
                        out_dest_d   = 4'(IMEM_ID);
                        out_opcode_d = 4'(PE_ID);
                    end
                end
            end
            S_REQ: if (out_hs) begin
                out_valid_d  = 1'b0;
                out_dest_d   = '0;
                out_opcode_d = '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            in_ready_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            out_dest_q   <= '0;
            out_opcode_q <= '0;
            out_data_q   <= '0;
            wptr_q       <= '0;
            row_cnt_q    <= '0;
            dest_pe_q    <= '0;
            err_q        <= 1'b0;
            col_q        <= '0;
            tap_q        <= '0;
        end else begin
            state_q      <= state_d;
            in_ready_q   <= in_ready_d;
            out_valid_q  <= out_valid_d;
            out_dest_q   <= out_dest_d;
            out_opcode_q <= out_opcode_d;
            out_data_q   <= out_data_d;
            wptr_q       <= wptr_d;
            row_cnt_q    <= row_cnt_d;
            dest_pe_q    <= dest_pe_d;
            err_q        <= err_d;
            col_q        <= col_d;
            tap_q        <= tap_d;
        end
    end

    always_ff @(posedge clk) begin
        acc_q    <= acc_d;
        spike_q  <= spike_d;
        weight_q <= weight_d;
    end

    assign in_ready       = in_ready_q;
    assign out_valid      = out_valid_q;
    assign out_dest       = out_dest_q;
    assign out_opcode     = out_opcode_q;
    assign out_data       = out_data_q;
    assign weights_loaded = loaded;
    assign busy           = (state_q != S_IDLE);
    assign row_cnt        = row_cnt_q;
    assign err            = err_q;
endmodule

// File: tb/tb_ppe_stream_engine.sv
// Directed bench for ppe_stream_engine: weight load, row streaming, round-robin dests,
// IMEM requests, back-pressure, row budget, drops and mid-row reset.
module tb_ppe_stream_engine;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_opcode;
    logic [24:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_dest;
    logic [3:0]  out_opcode;
    logic [24:0] out_data;
    logic        weights_loaded;
    logic        busy;
    logic [2:0]  row_cnt;
    logic        err;

    ppe_stream_engine dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_dest(out_dest),
        .out_opcode(out_opcode), .out_data(out_data),
        .weights_loaded(weights_loaded), .busy(busy), .row_cnt(row_cnt), .err(err)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          wm [5];
    int          exp_dest = 0;
    logic [24:0] got [21];
    logic        e;
    logic [3:0]  pd, po;
    logic [24:0] pdat, hold_data;
    int          waited;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [24:0] exp_sum(input logic [24:0] spk, input int c);
        int s = 0;
        for (int t = 0; t < 5; t++) if (spk[c+t]) s += wm[t];
        return s[24:0];
    endfunction

    task automatic send_pkt(input logic [3:0] op, input logic [24:0] d, output logic er);
        int n = 0;
        while (!in_ready && n < 300) begin tick(); n++; end
        if (!in_ready) chk("in_ready_timeout", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1; in_opcode = op; in_data = d;
        tick();
        in_valid = 1'b0;
        er = err;
    endtask

    task automatic get_pkt(output logic [3:0] d, output logic [3:0] o, output logic [24:0] x,
                           output int w);
        w = 0;
        while (!out_valid && w < 100) begin tick(); w++; end
        if (!out_valid) chk("out_valid_timeout", {31'd0, out_valid}, 32'd1);
        d = out_dest; o = out_opcode; x = out_data;
        tick();
    endtask

    task automatic collect_row(input logic [24:0] spk, input int c0, input bit req);
        for (int c = c0; c < 21; c++) begin
            get_pkt(pd, po, pdat, waited);
            chk($sformatf("latency_c%0d", c), waited, 5);
            chk($sformatf("dest_c%0d", c), {28'd0, pd}, exp_dest);
            chk($sformatf("opcode_c%0d", c), {28'd0, po}, 32'd0);
            chk($sformatf("data_c%0d", c), {7'd0, pdat}, {7'd0, exp_sum(spk, c)});
            got[c] = pdat;
            exp_dest = (exp_dest + 1) % 5;
        end
        if (req) begin
            get_pkt(pd, po, pdat, waited);
            chk("req_latency", waited, 0);
            chk("req_dest", {28'd0, pd}, 32'd11);
            chk("req_opcode", {28'd0, po}, 32'd0);
            chk("req_data", {7'd0, pdat}, 32'd0);
        end
        chk("busy_after_row", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_opcode = '0; in_data = '0; out_ready = 1'b1;
        #12;
        chk("rst_in_ready", {31'd0, in_ready}, 0);
        chk("rst_out_valid", {31'd0, out_valid}, 0);
        chk("rst_out_bus", {out_dest, out_opcode, out_data[23:0]}, 0);
        chk("rst_loaded", {31'd0, weights_loaded}, 0);
        chk("rst_row_cnt", {29'd0, row_cnt}, 0);
        chk("rst_err_busy", {30'd0, err, busy}, 0);
        @(negedge clk); rst_n = 1'b1;
        tick();
        chk("in_ready_after_rst", {31'd0, in_ready}, 1);

        // Weights 1..5, all-ones row
        wm = '{1, 2, 3, 4, 5};
        send_pkt(4'd0, 25'h030201, e);
        chk("loaded_partial", {31'd0, weights_loaded}, 0);
        send_pkt(4'd0, 25'h000504, e);
        chk("loaded_full", {31'd0, weights_loaded}, 1);
        chk("weight_no_err", {31'd0, e}, 0);
        send_pkt(4'd1, 25'h1FFFFFF, e);
        chk("busy_in_mac", {31'd0, busy}, 1);
        collect_row(25'h1FFFFFF, 0, 1'b1);
        chk("r1_sum15", {7'd0, got[10]}, 32'd15);
        chk("r1_row_cnt", {29'd0, row_cnt}, 1);

        // Timestep done: row counter and dest rewind
        send_pkt(4'd15, 25'h0, e);
        exp_dest = 0;
        chk("ts_row_cnt", {29'd0, row_cnt}, 0);
        chk("ts_keeps_weights", {31'd0, weights_loaded}, 1);

        send_pkt(4'd1, 25'h0000010, e);
        collect_row(25'h0000010, 0, 1'b1);
        chk("r2_col0", {7'd0, got[0]}, 5);
        chk("r2_col1", {7'd0, got[1]}, 4);
        chk("r2_col2", {7'd0, got[2]}, 3);
        chk("r2_col3", {7'd0, got[3]}, 2);
        chk("r2_col4", {7'd0, got[4]}, 1);
        chk("r2_col5", {7'd0, got[5]}, 0);
        chk("r2_col20", {7'd0, got[20]}, 0);

        // Reload with -128 taps (restart while loaded)
        wm = '{-128, -128, -128, -128, -128};
        send_pkt(4'd0, 25'h808080, e);
        chk("reload_restart", {31'd0, weights_loaded}, 0);
        send_pkt(4'd0, 25'h008080, e);
        send_pkt(4'd1, 25'h1FFFFFF, e);
        collect_row(25'h1FFFFFF, 0, 1'b1);
        chk("r3_neg640", {7'd0, got[7]}, {7'd0, 25'h1FFFD80});
        chk("r3_row_cnt", {29'd0, row_cnt}, 2);

        // Back-pressure during SEND
        out_ready = 1'b0;
        send_pkt(4'd1, 25'h1FFFFFF, e);
        waited = 0;
        while (!out_valid && waited < 100) begin tick(); waited++; end
        hold_data = out_data;
        chk("stall_first_data", {7'd0, hold_data}, {7'd0, 25'h1FFFD80});
        for (int i = 0; i < 10; i++) begin
            tick();
            chk($sformatf("stall_valid_%0d", i), {31'd0, out_valid}, 1);
            chk($sformatf("stall_data_%0d", i), {7'd0, out_data}, {7'd0, hold_data});
        end
        chk("stall_dest", {28'd0, out_dest}, exp_dest);
        out_ready = 1'b1;
        tick();
        exp_dest = (exp_dest + 1) % 5;
        collect_row(25'h1FFFFFF, 1, 1'b1);
        chk("r4_row_cnt", {29'd0, row_cnt}, 3);

        send_pkt(4'd1, 25'h0000010, e);
        collect_row(25'h0000010, 0, 1'b1);
        send_pkt(4'd1, 25'h0000010, e);
        collect_row(25'h0000010, 0, 1'b0);
        tick(); tick();
        chk("budget_no_req", {31'd0, out_valid}, 0);
        chk("budget_row_cnt", {29'd0, row_cnt}, 5);

        // Sixth row exceeds the budget
        send_pkt(4'd1, 25'h1FFFFFF, e);
        chk("row6_err", {31'd0, e}, 1);
        tick();
        chk("row6_err_pulse", {31'd0, err}, 0);
        chk("row6_no_out", {30'd0, out_valid, busy}, 0);

        send_pkt(4'd15, 25'h0, e);
        exp_dest = 0;
        send_pkt(4'd1, 25'h0000010, e);
        collect_row(25'h0000010, 0, 1'b1);
        chk("r8_first", {7'd0, got[0]}, {7'd0, 25'h1FFFF80});
        chk("r8_row_cnt", {29'd0, row_cnt}, 1);

        send_pkt(4'd7, 25'h0, e);
        chk("bad_opcode_err", {31'd0, e}, 1);

        // Reset in the middle of MAC
        send_pkt(4'd1, 25'h1FFFFFF, e);
        tick(); tick();
        chk("pre_rst_busy", {31'd0, busy}, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", {31'd0, out_valid}, 0);
        chk("mid_rst_row_cnt", {29'd0, row_cnt}, 0);
        chk("mid_rst_loaded", {31'd0, weights_loaded}, 0);
        chk("mid_rst_busy", {31'd0, busy}, 0);
        @(negedge clk); rst_n = 1'b1;
        tick();
        chk("post_rst_in_ready", {31'd0, in_ready}, 1);

        // Input before any weights
        send_pkt(4'd1, 25'h1FFFFFF, e);
        chk("noweights_err", {31'd0, e}, 1);
        for (int i = 0; i < 8; i++) tick();
        chk("noweights_no_out", {30'd0, out_valid, busy}, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/ppe_stream_engine.md
# ppe_stream_engine

Clocked, parametrised partial-sum processing element for the SNN convolution mesh. It sits between a depacketizer (input side) and a packetizer (output side) on a valid/ready packet interface. It stores a FILTER_SIZE-tap signed weight row and one IFMAP_SIZE-bit spike row, then streams one partial sum per output column to the SPEs in round-robin order. After each row it requests the next input row from IMEM, with a row budget per timestep.

## Interface
- FILTER_SIZE, 5, taps per weight row; must be ≥2.
- IFMAP_SIZE, 25, spike bits per input row; must be ≤25 and >FILTER_SIZE.
- WEIGHT_WIDTH, 8, signed weight width; must be ≤12.
- SUM_WIDTH, 14, signed accumulator width; must be ≥WEIGHT_WIDTH+$clog2(FILTER_SIZE)+1.
- NUM_SPE, 5, number of round-robin sum destinations (SPE ids 0..NUM_SPE-1).
- ROWS_PER_TS, 5, input rows consumed per timestep.
- PE_ID, 0, own id; used as opcode of the IMEM request packet.
- IMEM_ID, 11, IMEM destination address.
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- in_valid  in  1  depacketized packet available.
- in_ready  out  1  engine accepts a packet.
- in_opcode  in  4  0 = weights, 1 = input row, 15 = timestep done.
- in_data  in  25  packet payload.
- out_valid  out  1  outgoing packet valid.
- out_ready  in  1  packetizer accepts.
- out_dest  out  4  destination address.
- out_opcode  out  4  outgoing opcode.
- out_data  out  25  outgoing payload.
- weights_loaded  out  1  all FILTER_SIZE taps written.
- busy  out  1  state ≠ IDLE.
- row_cnt  out  3  rows processed in the current timestep.
- err  out  1  one-cycle pulse on a dropped packet.

## Operation
- States: IDLE, MAC, SEND, REQ.
- in_ready = 1 only in IDLE. A packet is accepted on a clk edge where in_valid & in_ready.
- Weight packet (opcode 0):
  - K = floor(25/WEIGHT_WIDTH) taps per packet. Tap k is data[(k+1)*WEIGHT_WIDTH-1 -: WEIGHT_WIDTH] and is written to wptr+k.
  - Writes at index ≥FILTER_SIZE are discarded. wptr advances by K and saturates at FILTER_SIZE.
  - weights_loaded = (wptr == FILTER_SIZE). State stays IDLE.
  - A weight packet arriving with weights_loaded = 1 restarts loading: wptr := 0, then the packet is written as the first.
- Input packet (opcode 1):
  - If weights_loaded = 0: the packet is dropped, err pulses, state stays IDLE.
  - Otherwise: store data[IFMAP_SIZE-1:0] (bit k = spike k), col := 0, tap := 0, acc := 0, go to MAC.
- MAC: one tap per cycle, acc += spike[col+tap] ? weight[tap] : 0, with signed, exact arithmetic. After tap FILTER_SIZE-1, go to SEND.
- SEND:
  - out_dest = dest_pe, out_opcode = 0, out_data = acc sign-extended to 25 bits.
  - On handshake, dest_pe := (dest_pe+1) mod NUM_SPE and col++.
  - If col was OUTPUT_DIM-1 (OUTPUT_DIM = IFMAP_SIZE-FILTER_SIZE+1), row_cnt++ and go to REQ if the new row_cnt < ROWS_PER_TS, else IDLE. Otherwise tap := 0, acc := 0, go to MAC.
- REQ: out_dest = IMEM_ID, out_opcode = PE_ID[3:0], out_data = 0. On handshake, go to IDLE.
- Timestep done (opcode 15): row_cnt := 0, dest_pe := 0; weights are retained; state stays IDLE.
- An input packet arriving with row_cnt == ROWS_PER_TS is dropped and err pulses.
- Any other opcode is dropped and err pulses.

## Timing
- Reset (rst_n low): state IDLE, in_ready 0, out_valid 0, out_dest/out_opcode/out_data 0, wptr 0, weights_loaded 0, row_cnt 0, dest_pe 0, err 0. Weight and spike storage contents are don't-care.
- in_ready rises on the first clk edge after rst_n deasserts.
- Accept edge = cycle 0. MAC occupies cycles 1..FILTER_SIZE. out_valid is registered high from cycle FILTER_SIZE+1.
- out_valid holds and out_* stay stable until the handshake. out_valid drops, or the next packet is presented, on the following edge.
- With out_ready tied 1, a row takes OUTPUT_DIM*(FILTER_SIZE+1) cycles, plus 1 REQ cycle, plus 1 return cycle to IDLE.
- dest_pe wraps NUM_SPE-1 → 0 and persists across rows within a timestep.
- A reset asserted mid-row aborts immediately. Any packet whose handshake had not completed is not sent.

## Test plan
- Weights 1,2,3,4,5 (packets 0x030201, 0x000504), input 0x1FFFFFF → 21 packets of out_data 15 with dests 0,1,2,3,4,0,…,0. Then REQ dest 11, opcode PE_ID, data 0. row_cnt = 1.
- Same weights, input 0x0000010 (spike 4) → col0 = 5, col1 = 4, col2 = 3, col3 = 2, col4 = 1, all other columns 0.
- Weights all 0x80 (−128), input all ones → each out_data = 25'h1FFFD80 (−640).
- out_ready held low 10 cycles during SEND → out_valid held high, out_data unchanged, no extra packet emitted.
- Five input rows → REQ after rows 1–4 only. A sixth row is dropped with err. After opcode 15, the next row's first sum goes to dest 0 and a REQ follows.
- Input before weights → err pulse, no output. rst_n pulsed low mid-MAC → out_valid 0, row_cnt 0, weights_loaded 0.
